// File: rtl/sram_arbiter_pkg.sv
// Shared SRAM bus constants and arbiter state encoding.
package sram_arbiter_pkg;
  localparam int SRAM_AW = 19;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_TURN  = 2'd3
  } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching from ptr+1, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] p;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    p   = '0;
    for (int i = 1; i <= N; i++) begin
      p = IW'((int'(ptr) + i) % N);
      if (!any && req[p]) begin
        any    = 1'b1;
        idx    = p;
        gnt[p] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_arbiter.sv
// Round-robin sharing of one SRAM local bus between NREQ requesters, with
// read->write turnaround and read-data routing back to the issuing port.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter  int NREQ         = 4,
  parameter  int READ_LATENCY = 2,
  parameter  int AW           = SRAM_AW,
  parameter  int DW           = SRAM_DW,
  localparam int IW           = $clog2(NREQ)
) (
  input  logic                      pclk,
  input  logic                      resetn,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ-1:0][1:0]      req_be,
  input  logic [NREQ-1:0][AW-1:0]   req_addr,
  input  logic [NREQ-1:0][DW-1:0]   req_wdata,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [DW-1:0]             rsp_data,
  output logic                      lower_byte,
  output logic                      upper_byte,
  output logic                      write_enable,
  output logic [AW-1:0]             address,
  output logic [DW-1:0]             write_data,
  input  logic [DW-1:0]             read_data
);
  arb_state_e state, state_nxt;
  logic [IW-1:0]   ptr, win_idx;
  logic [NREQ-1:0] win_oh;
  logic            win_any, win_we, turn_block, accept;

  // Read tags: stage 0 loads on the accept edge; the tail lines up with valid read_data.
  logic [READ_LATENCY:0]         vld_pipe;
  logic [READ_LATENCY:0][IW-1:0] id_pipe;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (win_oh),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    win_we     = req_we[win_idx];
    turn_block = (state == ST_READ) && win_we;
    accept     = resetn && win_any && (state != ST_TURN) && !turn_block;
    req_ready  = accept ? win_oh : '0;
    state_nxt  = ST_IDLE;
    if (accept)                  state_nxt = win_we ? ST_WRITE : ST_READ;
    else if (win_any && turn_block) state_nxt = ST_TURN;
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Bus registers: address/data hold when idle so the bus does not toggle needlessly.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      ptr          <= IW'(NREQ - 1);
      write_enable <= 1'b0;
      lower_byte   <= 1'b0;
      upper_byte   <= 1'b0;
      address      <= '0;
      write_data   <= '0;
    end else if (accept) begin
      ptr          <= win_idx;
      write_enable <= win_we;
      lower_byte   <= req_be[win_idx][0];
      upper_byte   <= req_be[win_idx][1];
      address      <= req_addr[win_idx];
      write_data   <= req_wdata[win_idx];
    end else begin
      write_enable <= 1'b0;
      lower_byte   <= 1'b0;
      upper_byte   <= 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe  <= '0;
      id_pipe   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[READ_LATENCY-1:0], accept && !win_we};
      id_pipe   <= {id_pipe[READ_LATENCY-1:0], win_idx};
      rsp_valid <= '0;
      if (vld_pipe[READ_LATENCY]) begin
        rsp_valid[id_pipe[READ_LATENCY]] <= 1'b1;
        rsp_data                         <= read_data;
      end
    end
  end
endmodule
